// File: rtl/serial_add_pkg.sv
// Shared types and width helpers for the bit-serial adder scheduler.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a range of w values, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned w);
        if (w <= 1) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_sched_add_bit.sv
// Single 1-bit full-adder cell shared by all requesters; purely combinational.
module add_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic o,
    output logic cout
);

    assign o    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler that time-shares one full-adder cell to perform
// W-bit additions bit-serially, LSB first, on behalf of N requesters.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        a,
    input  logic [N*W-1:0]        b,
    output logic [N-1:0]          gnt,
    output logic                  busy,
    output logic [cnt_w(N)-1:0]   owner,
    output logic [W-1:0]          sum,
    output logic                  cout,
    output logic                  valid
);

    localparam int unsigned OW    = cnt_w(N);
    localparam int unsigned CNT_W = cnt_w(W);

    state_t           state;
    state_t           state_d;

    logic [OW-1:0]    ptr;
    logic [OW-1:0]    win;
    logic [OW-1:0]    ptr_nxt;
    logic             found;
    logic [N-1:0]     rot;

    logic [W-1:0]     a_win;
    logic [W-1:0]     b_win;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     s_sr;
    logic [W-1:0]     s_shift;
    logic             carry;
    logic             add_o;
    logic             add_cout;

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             load;
    logic             step;

    // Rotate requests so the round-robin pointer lands on bit 0.
    always_comb begin
        rot = N'({req, req} >> ptr);
    end

    // First set request at or after ptr, converted back to an absolute index.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                win   = OW'((int'(ptr) + k) % int'(N));
            end
        end
    end

    // Pointer advances to the requester just after the winner, wrapping at N.
    always_comb begin
        ptr_nxt = (32'(win) == N - 1) ? '0 : win + OW'(1);
    end

    // Operand mux selecting the winning requester's slice.
    always_comb begin
        a_win = '0;
        b_win = '0;
        for (int i = 0; i < N; i++) begin
            if (win == OW'(i)) begin
                a_win = a[i*W +: W];
                b_win = b[i*W +: W];
            end
        end
    end

    add_bit u_add_bit (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry),
        .o    (add_o),
        .cout (add_cout)
    );

    assign last    = (cnt == CNT_W'(W - 1));
    assign s_shift = (s_sr >> 1) | (W'(add_o) << (W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic, grant pulse and datapath enables.
    always_comb begin
        state_d = state;
        gnt     = '0;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt     = N'(1) << win;
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter pointer, owner, operand shift registers, carry and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            owner <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            owner <= win;
            ptr   <= ptr_nxt;
            a_sr  <= a_win;
            b_sr  <= b_win;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_shift;
            carry <= add_cout;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result capture on the final bit so sum/cout are valid during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            cout  <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            valid <= (state_d == DONE);
            busy  <= (state_d != IDLE);
            if (step && last) begin
                sum  <= s_shift;
                cout <= add_cout;
            end
        end
    end

endmodule
